// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP issue controller: mode encodings, the
// controller state type and the per-mode DSP latency constants.
package dsp_pkg;

  // Precision modes understood by the DSP multiplier.
  localparam logic [1:0] MODE_SHORT   = 2'b00;
  localparam logic [1:0] MODE_MIXED   = 2'b01;
  localparam logic [1:0] MODE_FULL    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // Cycles the DSP needs after the start cycle before compare_res fires.
  localparam int LAT_SHORT = 0;
  localparam int LAT_MIXED = 1;
  localparam int LAT_FULL  = 3;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // True for every mode the DSP can execute.
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/dsp_res_slot.sv
// Result holding register: captures one result (data + error flag) and
// presents it on a valid/ready channel until the consumer takes it.
module dsp_res_slot #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_err,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         res_err
);

  // Load a new result, hold it while the consumer stalls, drop valid on handshake.
  // NOTE: every register here is written with <= so all flops update together
  // at the edge; blocking assignments would make the result depend on
  // statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= load_data;
      res_err   <= load_err;
    end else if (res_valid && res_ready) begin
      // Data and error keep their last values after the handshake.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dsp_issue_ctrl.sv
// Operand issue and result capture stage in front of the precision-scalable
// DSP multiplier. One operation in flight: accept, pulse start, wait for
// compare_res (or time out), then hand the result back over valid/ready.
module dsp_issue_ctrl
  import dsp_pkg::*;
#(
  parameter int N       = 9,
  parameter int M       = 9,
  parameter int TIMEOUT = 7
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [N-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  input  logic [N+M-1:0]   in_c,
  input  logic             in_mac,
  input  logic [1:0]       in_shift,
  // DSP side
  output logic             dsp_start,
  output logic [1:0]       dsp_mode,
  output logic [N-1:0]     dsp_aa,
  output logic [M-1:0]     dsp_bb,
  output logic [N+M-1:0]   dsp_cc,
  output logic             dsp_mac,
  output logic [1:0]       dsp_barrel_shifter,
  input  logic [N+M-1:0]   dsp_out,
  input  logic             dsp_compare_res,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N+M-1:0]   res_data,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state;
  logic [CW-1:0]   wait_cnt;
  logic            timeout_hit;
  logic            cap_load;
  logic            cap_err;
  logic [N+M-1:0]  cap_data;

  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  // Decide when the result slot is loaded and with what.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    cap_load = 1'b0;
    cap_err  = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (!mode_is_legal(dsp_mode)) begin
          // Illegal requests never start the DSP; they return an error.
          cap_load = 1'b1;
          cap_err  = 1'b1;
        end else if (dsp_compare_res) begin
          cap_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dsp_compare_res) begin
          cap_load = 1'b1;
        end else if (timeout_hit) begin
          cap_load = 1'b1;
          cap_err  = 1'b1;
        end
      end
      default: begin
        // compare_res outside ISSUE/WAIT belongs to no operation here.
      end
    endcase
    cap_data = cap_err ? '0 : dsp_out;
  end

  // Control FSM with registered handshake, start and operand outputs.
  // NOTE: the async reset clears operand registers too, so the DSP inputs
  // come out of reset at a known zero rather than whatever powered up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      in_ready           <= 1'b1;
      busy               <= 1'b0;
      dsp_start          <= 1'b0;
      dsp_mode           <= '0;
      dsp_aa             <= '0;
      dsp_bb             <= '0;
      dsp_cc             <= '0;
      dsp_mac            <= 1'b0;
      dsp_barrel_shifter <= '0;
      wait_cnt           <= '0;
    end else begin
      dsp_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dsp_mode           <= in_mode;
            dsp_aa             <= in_a;
            dsp_bb             <= in_b;
            dsp_cc             <= in_c;
            dsp_mac            <= in_mac;
            dsp_barrel_shifter <= in_shift;
            // Every request spends one issue cycle, so an illegal request
            // answers with the same two-cycle latency as a short one, just
            // without the start pulse.
            dsp_start          <= mode_is_legal(in_mode);
            in_ready           <= 1'b0;
            busy               <= 1'b1;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= cap_load ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (cap_load) begin
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // The result slot drops res_valid on this same edge.
          if (res_ready) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dsp_res_slot #(
    .W (N + M)
  ) u_res_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (cap_load),
    .load_data (cap_data),
    .load_err  (cap_err),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err)
  );

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Self-checking bench for dsp_issue_ctrl. A behavioural DSP model answers
// start pulses; a reference model predicts latency, data and error from the
// request fields alone.
module tb_dsp_issue_ctrl;

  localparam int N       = 9;
  localparam int M       = 9;
  localparam int TIMEOUT = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = '0;
  logic [N-1:0]     in_a = '0;
  logic [M-1:0]     in_b = '0;
  logic [N+M-1:0]   in_c = '0;
  logic             in_mac = 1'b0;
  logic [1:0]       in_shift = '0;
  logic             dsp_start;
  logic [1:0]       dsp_mode;
  logic [N-1:0]     dsp_aa;
  logic [M-1:0]     dsp_bb;
  logic [N+M-1:0]   dsp_cc;
  logic             dsp_mac;
  logic [1:0]       dsp_barrel_shifter;
  logic [N+M-1:0]   dsp_out;
  logic             dsp_compare_res;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [N+M-1:0]   res_data;
  logic             res_err;
  logic             busy;

  int passed = 0;
  int total  = 0;
  bit dsp_en = 1'b1;

  always #5 clk = ~clk;

  dsp_issue_ctrl #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_mode            (in_mode),
    .in_a               (in_a),
    .in_b               (in_b),
    .in_c               (in_c),
    .in_mac             (in_mac),
    .in_shift           (in_shift),
    .dsp_start          (dsp_start),
    .dsp_mode           (dsp_mode),
    .dsp_aa             (dsp_aa),
    .dsp_bb             (dsp_bb),
    .dsp_cc             (dsp_cc),
    .dsp_mac            (dsp_mac),
    .dsp_barrel_shifter (dsp_barrel_shifter),
    .dsp_out            (dsp_out),
    .dsp_compare_res    (dsp_compare_res),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_err            (res_err),
    .busy               (busy)
  );

  // Arithmetic the DSP stand-in performs (signed product plus addend, or
  // shifted product in mac mode).
  function automatic logic [N+M-1:0] dsp_calc(input logic [N-1:0] a, input logic [M-1:0] b,
                                              input logic [N+M-1:0] c, input logic mac,
                                              input logic [1:0] sh);
    logic signed [N+M-1:0] p;
    p = $signed(a) * $signed(b);
    return mac ? (p <<< sh) : (p + $signed(c));
  endfunction

  // DSP stand-in: mode 00 answers in the start cycle, 01 one cycle later,
  // 10 three cycles later.
  logic             dsp_run;
  logic [2:0]       dsp_cnt;
  logic [N+M-1:0]   dsp_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_run  <= 1'b0;
      dsp_cnt  <= '0;
      dsp_hold <= '0;
    end else if (dsp_start && (dsp_mode == 2'b01 || dsp_mode == 2'b10)) begin
      dsp_run  <= 1'b1;
      dsp_cnt  <= (dsp_mode == 2'b01) ? 3'd1 : 3'd3;
      dsp_hold <= dsp_calc(dsp_aa, dsp_bb, dsp_cc, dsp_mac, dsp_barrel_shifter);
    end else if (dsp_run) begin
      dsp_cnt <= dsp_cnt - 3'd1;
      if (dsp_cnt == 3'd1) dsp_run <= 1'b0;
    end
  end

  always_comb begin
    dsp_compare_res = dsp_en && ((dsp_start && dsp_mode == 2'b00) || (dsp_run && dsp_cnt == 3'd1));
    dsp_out = (dsp_start && dsp_mode == 2'b00)
            ? dsp_calc(dsp_aa, dsp_bb, dsp_cc, dsp_mac, dsp_barrel_shifter) : dsp_hold;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: cycles from acceptance to first res_valid, plus result.
  task automatic ref_model(input logic [1:0] mode, input logic [N-1:0] a, input logic [M-1:0] b,
                           input logic [N+M-1:0] c, input logic mac, input logic [1:0] sh,
                           output int lat, output logic [N+M-1:0] data, output logic err);
    if (mode == 2'b11) begin
      lat = 2; data = '0; err = 1'b1;
    end else if (!dsp_en) begin
      lat = 2 + TIMEOUT; data = '0; err = 1'b1;
    end else begin
      lat  = (mode == 2'b00) ? 2 : (mode == 2'b01) ? 3 : 5;
      data = dsp_calc(a, b, c, mac, sh);
      err  = 1'b0;
    end
  endtask

  // One complete request/result transaction with full checking.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [N-1:0] a,
                        input logic [M-1:0] b, input logic [N+M-1:0] c, input logic mac,
                        input logic [1:0] sh);
    int lat_exp, lat_obs, starts, guard;
    logic [N+M-1:0] d_exp;
    logic e_exp;
    bit stable;
    ref_model(mode, a, b, c, mac, sh, lat_exp, d_exp, e_exp);
    @(negedge clk);
    in_valid = 1'b1; in_mode = mode; in_a = a; in_b = b; in_c = c; in_mac = mac; in_shift = sh;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s_ready", tag), in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("%s_start_t1", tag), dsp_start, mode != 2'b11);
    starts  = dsp_start ? 1 : 0;
    stable  = 1'b1;
    lat_obs = -1;
    for (int k = 1; k <= 20 && lat_obs < 0; k++) begin
      if (dsp_aa !== a || dsp_bb !== b || dsp_cc !== c || dsp_mode !== mode ||
          dsp_mac !== mac || dsp_barrel_shifter !== sh) stable = 1'b0;
      @(posedge clk); #1;
      if (dsp_start) starts++;
      if (res_valid) lat_obs = k + 1;
    end
    check($sformatf("%s_latency", tag), 64'(lat_obs), 64'(lat_exp));
    check($sformatf("%s_data", tag), res_data, d_exp);
    check($sformatf("%s_err", tag), res_err, e_exp);
    check($sformatf("%s_starts", tag), 64'(starts), (mode == 2'b11) ? 64'd0 : 64'd1);
    check($sformatf("%s_stable", tag), stable, 1'b1);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check($sformatf("%s_released", tag), {res_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N+M-1:0] held;
    int guard;

    // Reset state
    #12;
    check("rst_outputs", {in_ready, res_valid, dsp_start, busy, res_err}, 5'b10000);
    check("rst_data", {res_data, dsp_aa, dsp_bb}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed mode examples
    run_op("m00", 2'b00, 9'h003, 9'h005, 18'd10, 1'b0, 2'd0);
    run_op("m01", 2'b01, 9'h002, 9'h014, 18'd0, 1'b0, 2'd0);
    run_op("m10", 2'b10, 9'h1FD, 9'h007, 18'd100, 1'b0, 2'd0);
    run_op("m11", 2'b11, 9'h011, 9'h022, 18'd5, 1'b0, 2'd0);
    run_op("mac", 2'b01, 9'h1F0, 9'h003, 18'd0, 1'b1, 2'd2);

    // Timeout: DSP never answers
    dsp_en = 1'b0;
    run_op("tmo", 2'b10, 9'h004, 9'h004, 18'd1, 1'b0, 2'd0);
    dsp_en = 1'b1;

    // Backpressure: result held while a new request waits
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b00; in_a = 9'd7; in_b = 9'd9; in_c = 18'd1; in_mac = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_valid", res_valid, 1'b1);
    check("bp_data", res_data, 18'd64);
    held = res_data;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b01; in_a = 9'd4; in_b = 9'd5; in_c = 18'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), {res_valid, res_data, res_err, in_ready, dsp_start},
            {1'b1, held, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_handshake", {res_valid, in_ready, dsp_start}, 3'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pending_start", dsp_start, 1'b1);
    guard = 0;
    while (!res_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("bp_pending_lat", 64'(guard), 64'd2);
    check("bp_pending_data", {res_data, res_err}, {18'd20, 1'b0});
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset in the second WAIT cycle of a full-precision operation
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b10; in_a = 9'd3; in_b = 9'd3; in_c = 18'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst", {dsp_start, res_valid, in_ready, busy}, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 2'b00, 9'h00B, 9'h1FF, 18'd3, 1'b0, 2'd0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 9'($urandom), 9'($urandom),
             18'($urandom), 1'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
